spi_packet_framer: RTL
======================

# spi_packet_framer

Packet-level sequencer placed directly after the SPI byte receiver in the controller-input path. It consumes the receiver's byte stream (one-cycle strobes), hunts for a sync byte, assembles a fixed-length payload, and verifies an 8-bit additive checksum. Good packets are presented on a valid/ready output to the input-handling logic; bad, stalled or unconsumed packets are reported as error pulses. All logic is on the 100 MHz system clock.

## Interface
- PAYLOAD_BYTES, 4: payload bytes per packet, ≥1.
- SYNC_BYTE, 8'hA5: packet start marker.
- TIMEOUT_CYCLES, 100_000: maximum idle cycles between bytes inside a packet (1 ms).
- clk_in  input  1  system clock, 100 MHz.
- rst_in  input  1  reset, synchronous, active-high.
- byte_in  input  8  received byte; sampled only when byte_valid_in is high.
- byte_valid_in  input  1  one-cycle strobe from the byte receiver.
- packet_out  output  8*PAYLOAD_BYTES  payload; first received byte in the MSBs.
- packet_valid_out  output  1  packet_out holds an unconsumed good packet.
- packet_ready_in  input  1  consumer accepts the packet when valid && ready.
- csum_err_out  output  1  one-cycle pulse: checksum mismatch.
- timeout_err_out  output  1  one-cycle pulse: inter-byte timeout.
- overflow_err_out  output  1  one-cycle pulse: good packet dropped because output still held.
- busy_out  output  1  high in any state other than HUNT.

## Operation
- Frame: SYNC_BYTE, PAYLOAD_BYTES payload bytes, checksum byte = sum of payload bytes mod 256 (sync not included).
- States: HUNT, PAYLOAD, CSUM.
- HUNT: byte == SYNC_BYTE → PAYLOAD, clear byte index, running sum, timer. Other bytes are ignored.
- PAYLOAD: each byte is shifted into a staging register (left shift, new byte in LSBs) and added to an 8-bit running sum; index counts 0..PAYLOAD_BYTES-1. The last byte → CSUM. Sync-valued bytes are treated as data.
- CSUM: on a byte, compare it with the running sum. Match → commit staging to output; mismatch → pulse csum_err_out. Either way → HUNT.
- Commit: if packet_valid_out is low, or packet_ready_in is high in the same cycle, load packet_out and hold valid high. Otherwise drop the new packet, pulse overflow_err_out, and leave packet_out/valid unchanged.
- Handshake: valid falls the cycle after valid && ready, unless a commit happens in that cycle. packet_out is stable while valid is high and unaccepted.
- Timeout: in PAYLOAD/CSUM the timer counts cycles with no byte_valid_in and resets on every byte. When it reaches TIMEOUT_CYCLES-1 without a byte: pulse timeout_err_out, go to HUNT, discard staging. A byte arriving in that same cycle takes priority; no timeout occurs.
- Output register is independent of staging, so assembly continues while a packet is held.

## Timing
- Reset values: packet_out 0, packet_valid_out 0, all err pulses 0, busy_out 0, state HUNT, sum/index/timer 0.
- Reset mid-packet aborts the packet. A held packet is discarded with no error pulse.
- Checksum byte strobed at cycle T: packet_valid_out/packet_out update at T+1; csum_err_out or overflow_err_out is high during T+1 only.
- Timeout pulse occurs exactly TIMEOUT_CYCLES cycles after the last accepted in-packet byte.
- Back-to-back strobes on consecutive cycles are supported; there is no input backpressure.
- busy_out is registered from state.
- Sum arithmetic is 8-bit wrap-around. Index and timer widths come from $clog2 of their parameters.

## Structure
- Package spi_pkg: state enum (HUNT, PAYLOAD, CSUM) and default SYNC_BYTE constant.
- One sub-module, spi_timeout: clear/tick counter with terminal-count pulse, parameterised by TIMEOUT_CYCLES.
- FSM, staging, checksum and output register stay in spi_packet_framer.

## Test plan
- Good packet: A5,01,02,03,04,0A, consumer ready → packet_out=32'h01020304, valid for 1 cycle at T+1, no errors.
- Bad checksum: A5,01,02,03,04,0B → csum_err_out pulse at T+1, valid stays 0; next good packet accepted normally.
- Hunt/sync-as-data: 00,FF,A5,A5,00,00,00,A5 → packet 32'hA5000000 accepted.
- Timeout: A5,01 then 100_000 idle cycles → timeout_err_out exactly 100_000 cycles after 01, busy_out drops; a later full packet succeeds.
- Overflow and simultaneous accept:
  - ready low, two good packets → second dropped with overflow pulse, first still held.
  - Repeat with ready asserted in the commit cycle → second replaces the first, no overflow.
- Reset mid-packet: rst_in after A5,01,02 → all outputs 0 next cycle; subsequent full packet accepted.

Source files
------------

// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_pkg
// Description : Shared types and constants for the SPI packet framer.
//               state_t      - framer sequencer states
//               c_SYNC_BYTE_DEFAULT - default packet start marker
// Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    PAYLOAD = 2'd1,
    CSUM    = 2'd2
  } state_t;

  localparam logic [7:0] c_SYNC_BYTE_DEFAULT = 8'hA5;

endpackage : spi_pkg
`default_nettype wire

// File: rtl/spi_timeout.sv
`default_nettype none
// ============================================================================
// Module      : spi_timeout
// Description : Inter-byte idle timer with terminal-count pulse.
//               The count holds the number of cycles elapsed since the last
//               clear, so the terminal pulse lands TIMEOUT_CYCLES-1 idle
//               cycles after the clearing byte and the registered error in
//               the framer appears TIMEOUT_CYCLES cycles after that byte.
//               TIMEOUT_CYCLES must be at least 2.
// Ports       : clk_in     - system clock
//               rst_in     - synchronous active-high reset
//               i_clear    - restart the idle count (a byte arrived)
//               i_tick     - one idle cycle elapsed
//               o_terminal - combinational: idle limit reached this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module spi_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 100_000
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic i_clear,
  input  logic i_tick,
  output logic o_terminal
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] c_TERMINAL = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= CW'(1);
    end else if (i_tick && (r_count != c_TERMINAL)) begin
      r_count <= r_count + CW'(1);
    end
  end

  assign o_terminal = i_tick && (r_count == c_TERMINAL);

endmodule : spi_timeout
`default_nettype wire

// File: rtl/spi_packet_framer.sv
`default_nettype none
// ============================================================================
// Module      : spi_packet_framer
// Description : Hunts for a sync byte in the SPI receiver byte stream,
//               assembles PAYLOAD_BYTES payload bytes, verifies the 8-bit
//               additive checksum and presents good packets on a
//               valid/ready output. Errors are reported as one-cycle pulses.
// Ports       : clk_in           - 100 MHz system clock
//               rst_in           - synchronous active-high reset
//               byte_in          - received byte
//               byte_valid_in    - one-cycle byte strobe
//               packet_out       - payload, first byte in the MSBs
//               packet_valid_out - packet_out holds an unconsumed packet
//               packet_ready_in  - consumer accepts when valid && ready
//               csum_err_out     - pulse: checksum mismatch
//               timeout_err_out  - pulse: inter-byte timeout
//               overflow_err_out - pulse: good packet dropped, output held
//               busy_out         - framer is inside a packet
// Revision    : 1.0 - initial release
// ============================================================================
module spi_packet_framer
  import spi_pkg::*;
#(
  parameter int unsigned PAYLOAD_BYTES  = 4,
  parameter logic [7:0]  SYNC_BYTE      = c_SYNC_BYTE_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = 100_000
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic [7:0]                 byte_in,
  input  logic                       byte_valid_in,
  output logic [8*PAYLOAD_BYTES-1:0] packet_out,
  output logic                       packet_valid_out,
  input  logic                       packet_ready_in,
  output logic                       csum_err_out,
  output logic                       timeout_err_out,
  output logic                       overflow_err_out,
  output logic                       busy_out
);

  localparam int unsigned W     = 8 * PAYLOAD_BYTES;
  localparam int unsigned IDX_W = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;
  localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(PAYLOAD_BYTES - 1);

  state_t           r_state;
  state_t           w_next_state;
  logic [W-1:0]     r_staging;
  logic [W-1:0]     r_packet;
  logic             r_valid;
  logic [7:0]       r_sum;
  logic [IDX_W-1:0] r_idx;
  logic             r_csum_err;
  logic             r_timeout_err;
  logic             r_overflow_err;
  logic             r_busy;

  logic w_good;
  logic w_bad;
  logic w_commit;
  logic w_tick;
  logic w_tc;

  // The timer only runs inside a packet; any byte restarts it.
  assign w_tick = (r_state != HUNT) && !byte_valid_in;

  spi_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .i_clear    (byte_valid_in),
    .i_tick     (w_tick),
    .o_terminal (w_tc)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state <= HUNT;
    end else begin
      r_state <= w_next_state;
    end
  end

  // w_tc implies no byte this cycle, so an arriving byte always wins.
  always_comb begin
    w_next_state = r_state;
    w_good       = 1'b0;
    w_bad        = 1'b0;
    unique case (r_state)
      HUNT: begin
        if (byte_valid_in && (byte_in == SYNC_BYTE)) begin
          w_next_state = PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (byte_valid_in) begin
          if (r_idx == c_LAST_IDX) begin
            w_next_state = CSUM;
          end
        end else if (w_tc) begin
          w_next_state = HUNT;
        end
      end
      CSUM: begin
        if (byte_valid_in) begin
          w_next_state = HUNT;
          if (byte_in == r_sum) begin
            w_good = 1'b1;
          end else begin
            w_bad = 1'b1;
          end
        end else if (w_tc) begin
          w_next_state = HUNT;
        end
      end
      default: w_next_state = HUNT;
    endcase
  end

  // A held packet may be replaced only if it is consumed in the same cycle.
  assign w_commit = w_good && (!r_valid || packet_ready_in);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_staging      <= '0;
      r_packet       <= '0;
      r_valid        <= 1'b0;
      r_sum          <= '0;
      r_idx          <= '0;
      r_csum_err     <= 1'b0;
      r_timeout_err  <= 1'b0;
      r_overflow_err <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      r_csum_err     <= w_bad;
      r_timeout_err  <= w_tc;
      r_overflow_err <= w_good && r_valid && !packet_ready_in;
      r_busy         <= (w_next_state != HUNT);

      unique case (r_state)
        HUNT: begin
          if (byte_valid_in && (byte_in == SYNC_BYTE)) begin
            r_idx <= '0;
            r_sum <= '0;
          end
        end
        PAYLOAD: begin
          if (byte_valid_in) begin
            r_staging <= (r_staging << 8) | W'(byte_in);
            r_sum     <= r_sum + byte_in;
            r_idx     <= r_idx + IDX_W'(1);
          end else if (w_tc) begin
            r_staging <= '0;
          end
        end
        CSUM: begin
          if (w_tc) begin
            r_staging <= '0;
          end
        end
        default: ;
      endcase

      if (w_commit) begin
        r_packet <= r_staging;
        r_valid  <= 1'b1;
      end else if (r_valid && packet_ready_in) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign packet_out       = r_packet;
  assign packet_valid_out = r_valid;
  assign csum_err_out     = r_csum_err;
  assign timeout_err_out  = r_timeout_err;
  assign overflow_err_out = r_overflow_err;
  assign busy_out         = r_busy;

endmodule : spi_packet_framer
`default_nettype wire
